// File: rtl/mult_sched_pkg.sv
// Shared widths, FSM state type and counter helper for the mult_sched
// request scheduler.
package mult_sched_pkg;

    localparam int MN1_W     = 48;
    localparam int MN2_W     = 16;
    localparam int RES_W     = 32;
    localparam int OVR_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } sched_state_t;

    function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
        return (v == {OVR_CNT_W{1'b1}}) ? v : v + OVR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/mult.sv
// Combinational float multiplier: 48-bit (s/e8/f39) x 16-bit (s/e5/f10)
// operands, 32-bit (s/e8/f23) result; truncating with a sticky LSB.
module mult (
    input  logic [47:0] mn1,
    input  logic [15:0] mn2,
    output logic [31:0] result,
    output logic        ovr
);
    logic               sign_s;
    logic [7:0]         e1_s;
    logic [4:0]         e2_s;
    logic [10:0]        sig1_s;
    logic [10:0]        sig2_s;
    logic [21:0]        prod_s;
    logic [22:0]        frac_s;
    logic               sticky_s;
    logic signed [10:0] exp_s;

    // significand product, normalisation and range classification
    always_comb begin
        sign_s   = mn1[47] ^ mn2[15];
        e1_s     = mn1[46:39];
        e2_s     = mn2[14:10];
        sig1_s   = {1'b1, mn1[38:29]};
        sig2_s   = {1'b1, mn2[9:0]};
        sticky_s = |mn1[28:0];
        prod_s   = 22'(sig1_s) * 22'(sig2_s);
        exp_s    = $signed({3'b000, e1_s}) + $signed({6'b000000, e2_s})
                 + $signed({10'b0000000000, prod_s[21]}) - 11'sd15;
        if (prod_s[21]) begin
            frac_s = {prod_s[20:0], 2'b00};
        end else begin
            frac_s = {prod_s[19:0], 3'b000};
        end
        result = 32'h0000_0000;
        ovr    = 1'b0;
        if (e1_s == 8'h00 || e2_s == 5'h00 || exp_s <= 11'sd0) begin
            result = {sign_s, 31'h0000_0000};
        end else if (exp_s >= 11'sd255) begin
            result = {sign_s, 8'hFF, 23'h00_0000};
            ovr    = 1'b1;
        end else begin
            result = {sign_s, exp_s[7:0], frac_s[22:1], frac_s[0] | sticky_s};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr, wrapping
// modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any
);
    logic [ID_W-1:0] idx_s;
    logic            hit_s;

    // circular priority scan starting at ptr
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            idx_s        = ID_W'((int'(ptr) + off) % NREQ);
            hit_s        = !any && req[idx_s];
            gnt[idx_s]   = hit_s;
            gnt_idx      = hit_s ? idx_s : gnt_idx;
            any          = any | hit_s;
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Shares one mult instance among NREQ requesters: round-robin accept,
// one registered issue cycle, tagged response held under backpressure.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*MN1_W-1:0] req_mn1,
    input  logic [NREQ*MN2_W-1:0] req_mn2,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [RES_W-1:0]      rsp_result,
    output logic                  rsp_ovr,
    output logic                  busy,
    output logic [OVR_CNT_W-1:0]  ovr_count
);
    sched_state_t         state_r;
    sched_state_t         state_s;
    logic [ID_W-1:0]      ptr_r;
    logic [ID_W-1:0]      id_r;
    logic [ID_W-1:0]      gnt_idx_s;
    logic [NREQ-1:0]      gnt_s;
    logic                 any_s;
    logic                 accept_s;
    logic                 deliver_s;
    logic [MN1_W-1:0]     op1_r;
    logic [MN2_W-1:0]     op2_r;
    logic [RES_W-1:0]     mult_res_s;
    logic                 mult_ovr_s;
    logic                 rsp_valid_r;
    logic [ID_W-1:0]      rsp_id_r;
    logic [RES_W-1:0]     rsp_result_r;
    logic                 rsp_ovr_r;
    logic [OVR_CNT_W-1:0] ovr_cnt_r;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    mult u_mult (
        .mn1    (op1_r),
        .mn2    (op2_r),
        .result (mult_res_s),
        .ovr    (mult_ovr_s)
    );

    // next-state and handshake decode; ready is masked while reset is held
    always_comb begin
        state_s   = state_r;
        req_ready = '0;
        accept_s  = 1'b0;
        deliver_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rst_n) begin
                    req_ready = gnt_s;
                end else begin
                    req_ready = '0;
                end
                accept_s = any_s;
                state_s  = any_s ? ISSUE : IDLE;
            end
            ISSUE: begin
                state_s = RESP;
            end
            RESP: begin
                deliver_s = rsp_ready;
                state_s   = rsp_ready ? IDLE : RESP;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // operand capture and pointer advance at the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
            id_r  <= '0;
            op1_r <= '0;
            op2_r <= '0;
        end else if (accept_s) begin
            ptr_r <= (gnt_idx_s == ID_W'(NREQ - 1)) ? '0 : gnt_idx_s + ID_W'(1);
            id_r  <= gnt_idx_s;
            op1_r <= req_mn1[gnt_idx_s*MN1_W +: MN1_W];
            op2_r <= req_mn2[gnt_idx_s*MN2_W +: MN2_W];
        end
    end

    // response registers: load at end of ISSUE, drop valid on delivery
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_result_r <= '0;
            rsp_ovr_r    <= 1'b0;
        end else if (state_r == ISSUE) begin
            rsp_valid_r  <= 1'b1;
            rsp_id_r     <= id_r;
            rsp_result_r <= mult_res_s;
            rsp_ovr_r    <= mult_ovr_s;
        end else if (deliver_s) begin
            rsp_valid_r  <= 1'b0;
        end
    end

    // saturating count of delivered overflow responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt_r <= '0;
        end else if (deliver_s && rsp_ovr_r) begin
            ovr_cnt_r <= sat_inc(ovr_cnt_r);
        end
    end

    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_result = rsp_result_r;
    assign rsp_ovr    = rsp_ovr_r;
    assign busy       = (state_r != IDLE);
    assign ovr_count  = ovr_cnt_r;

endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched: single op, sign pair, round-robin order,
// backpressure, reset abort and saturating overflow count.
module tb_mult_sched;
    localparam logic [47:0] V1  = 48'h84FB70D0FE24;
    localparam logic [47:0] VBIG = 48'h780000000000;
    localparam logic [31:0] RP  = 32'h8437DDF9;
    localparam logic [31:0] RN  = 32'h0437DDF9;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [191:0] req_mn1;
    logic [63:0]  req_mn2;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_result;
    logic         rsp_ovr;
    logic         busy;
    logic [15:0]  ovr_count;
    int           nchk = 0;
    int           nerr = 0;

    mult_sched #(.NREQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_mn1(req_mn1), .req_mn2(req_mn2), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_ovr(rsp_ovr), .busy(busy), .ovr_count(ovr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [1:0] id, input logic [47:0] a, input logic [15:0] b,
                         input logic [31:0] er, input logic eo, input string tag);
        req_mn1[id*48 +: 48] = a;
        req_mn2[id*16 +: 16] = b;
        req_valid     = 4'b0000;
        req_valid[id] = 1'b1;
        #1;
        chk({tag, "_ready"}, 64'(req_ready), 64'(4'b0001 << id));
        tick();
        req_valid = 4'b0000;
        chk({tag, "_busy"}, 64'(busy), 64'(1'b1));
        chk({tag, "_early"}, 64'(rsp_valid), 64'(1'b0));
        tick();
        chk({tag, "_valid"}, 64'(rsp_valid), 64'(1'b1));
        chk({tag, "_id"}, 64'(rsp_id), 64'(id));
        chk({tag, "_result"}, 64'(rsp_result), 64'(er));
        chk({tag, "_ovr"}, 64'(rsp_ovr), 64'(eo));
        tick();
        chk({tag, "_done"}, 64'(rsp_valid), 64'(1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;
        int last;
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_mn1   = '0;
        req_mn2   = '0;
        rsp_ready = 1'b1;
        #3;
        chk("rst_ready", 64'(req_ready), 64'(4'b0000));
        chk("rst_valid", 64'(rsp_valid), 64'(1'b0));
        chk("rst_id", 64'(rsp_id), 64'(2'd0));
        chk("rst_result", 64'(rsp_result), 64'(32'h0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_count", 64'(ovr_count), 64'(16'h0));
        tick();
        rst_n = 1'b1;

        // single op and sign pair
        do_op(2'd0, V1, 16'h35DA, RP, 1'b0, "single");
        do_op(2'd1, V1, 16'h35DA, RP, 1'b0, "pair_pos");
        do_op(2'd1, V1, 16'hB5DA, RN, 1'b0, "pair_neg");

        // round-robin from ptr=0 after a fresh reset
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_mn1[i*48 +: 48] = V1;
            req_mn2[i*16 +: 16] = (i % 2 == 0) ? 16'h35DA : 16'hB5DA;
        end
        req_valid = 4'b1111;
        cyc  = 0;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 10) begin
                tick();
                n++;
                cyc++;
            end
            chk("rr_valid", 64'(rsp_valid), 64'(1'b1));
            chk("rr_id", 64'(rsp_id), 64'(k % 4));
            chk("rr_result", 64'(rsp_result), 64'((k % 2 == 0) ? RP : RN));
            if (k > 0) chk("rr_gap", 64'(cyc - last), 64'(3));
            last = cyc;
            tick();
            cyc++;
            if (k == 4) req_valid = 4'b0000;
        end

        // backpressure with a competing request pending
        rsp_ready = 1'b0;
        req_mn2[2*16 +: 16] = 16'h35DA;
        req_valid = 4'b0100;
        tick();
        req_mn2[3*16 +: 16] = 16'hB5DA;
        req_valid = 4'b1000;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(rsp_valid), 64'(1'b1));
            chk("bp_id", 64'(rsp_id), 64'(2'd2));
            chk("bp_result", 64'(rsp_result), 64'(RP));
            chk("bp_ready", 64'(req_ready), 64'(4'b0000));
            chk("bp_busy", 64'(busy), 64'(1'b1));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release", 64'(rsp_valid), 64'(1'b0));
        tick();
        req_valid = 4'b0000;
        tick();
        chk("bp_next_id", 64'(rsp_id), 64'(2'd3));
        chk("bp_next_result", 64'(rsp_result), 64'(RN));
        tick();

        // reset during ISSUE aborts the operation
        req_mn2[2*16 +: 16] = 16'hB5DA;
        req_valid = 4'b0100;
        tick();
        chk("abort_busy", 64'(busy), 64'(1'b1));
        req_mn2[2*16 +: 16] = 16'h35DA;
        rst_n = 1'b0;
        #1;
        chk("abort_busy_rst", 64'(busy), 64'(1'b0));
        chk("abort_ready_rst", 64'(req_ready), 64'(4'b0000));
        chk("abort_id_rst", 64'(rsp_id), 64'(2'd0));
        chk("abort_result_rst", 64'(rsp_result), 64'(32'h0));
        tick();
        chk("abort_no_rsp", 64'(rsp_valid), 64'(1'b0));
        rst_n = 1'b1;
        do_op(2'd2, V1, 16'h35DA, RP, 1'b0, "after_abort");
        chk("abort_count", 64'(ovr_count), 64'(16'h0));

        // overflow counting and saturation
        do_op(2'd0, VBIG, 16'h7800, 32'h7F800000, 1'b1, "ovr_a");
        chk("ovr_cnt1", 64'(ovr_count), 64'(16'd1));
        do_op(2'd1, VBIG, 16'h7C00, 32'h7F800000, 1'b1, "ovr_b");
        do_op(2'd2, V1, 16'h35DA, RP, 1'b0, "novr_a");
        do_op(2'd3, VBIG, 16'hF800, 32'hFF800000, 1'b1, "ovr_c");
        do_op(2'd0, VBIG, 16'h7400, 32'h7F000000, 1'b0, "novr_b");
        chk("ovr_cnt3", 64'(ovr_count), 64'(16'd3));
        force dut.ovr_cnt_r = 16'hFFFF;
        tick();
        release dut.ovr_cnt_r;
        do_op(2'd1, VBIG, 16'h7800, 32'h7F800000, 1'b1, "ovr_sat");
        chk("ovr_sat_cnt", 64'(ovr_count), 64'(16'hFFFF));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/mult_sched.md
# mult_sched

Round-robin scheduler that shares the single combinational `mult` floating-point multiplier (48-bit × 16-bit operands, 32-bit result plus overflow flag) between several requesters. It registers the granted operands, captures the product one cycle later, and returns it on one tagged response channel with backpressure. It sits between the datapath clients and `mult`, and is the only path by which clients reach the multiplier.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `ID_W`, `$clog2(NREQ)`: response tag width.

Ports:
- Clock/reset: one clock; reset is asynchronous and active-low.
  - `clk`: in, 1, rising-edge clock.
  - `rst_n`: in, 1, asynchronous active-low reset.
- Request side:
  - `req_valid`: in, NREQ, per-requester operand valid.
  - `req_ready`: out, NREQ, one-hot accept.
  - `req_mn1`: in, NREQ*48, packed operands; requester i is at [i*48 +: 48].
  - `req_mn2`: in, NREQ*16, packed operands; requester i is at [i*16 +: 16].
- Response side:
  - `rsp_valid`: out, 1, response valid.
  - `rsp_ready`: in, 1, consumer accepts the response.
  - `rsp_id`: out, ID_W, index of the requester that issued the operation.
  - `rsp_result`: out, 32, `mult` result.
  - `rsp_ovr`: out, 1, `mult` overflow flag.
- Status:
  - `busy`: out, 1, high in any state other than IDLE.
  - `ovr_count`: out, 16, saturating count of delivered responses with `rsp_ovr`=1.

## Operation
- FSM states IDLE, ISSUE, RESP.
  - **IDLE:** the grant is computed combinationally from `req_valid` and the round-robin pointer `ptr`. The search starts at `ptr` and takes the first valid index, wrapping modulo NREQ. `req_ready[g]`=1 only for the granted g.
    - Accept occurs when `req_valid[g]`&`req_ready[g]`. Then latch `req_mn1`/`req_mn2` slices into `op1`/`op2`, latch `id`←g, set `ptr`←(g+1) mod NREQ, and go to ISSUE.
    - With no valid requests, remain in IDLE and hold `ptr`.
  - **ISSUE:** `op1`/`op2` drive `mult`. At the clock edge, capture `result`/`ovr` into the response registers and go to RESP.
  - **RESP:** `rsp_valid`=1. The response registers stay stable until `rsp_ready`=1.
    - On `rsp_valid`&`rsp_ready`: increment `ovr_count` if `rsp_ovr`=1 (saturate at 16'hFFFF) and go to IDLE.
- `req_ready` is all-zero outside IDLE. Requests are never dropped; a requester holds `valid` and operands until accepted.
- `req_ready` may depend on `req_valid` (combinational grant). Requesters must not make `req_valid` depend on `req_ready`.
- Fairness: after any requester is served, every other continuously-valid requester is served before it is served again.
- Operand changes while not granted have no effect. Operands are sampled only at the accept edge.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - State IDLE, `ptr`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_ovr`=0, `busy`=0, `ovr_count`=0.
  - `op1`/`op2`=0.
- Reset asserted in ISSUE or RESP aborts the operation: no response is produced and the count is unchanged.
- Latency: accept at edge t; `rsp_valid`=1 from cycle t+2.
- Minimum initiation interval: 3 cycles (accept, ISSUE, RESP with `rsp_ready`=1, then IDLE accepts again).
- `rsp_ready` low in RESP stalls indefinitely with all response outputs stable. Requesters see `req_ready`=0 throughout.
- Simultaneous requests from all NREQ with `ptr`=k are granted in order k, k+1, …, wrapping.
- Counter saturation: an ovr response delivered when `ovr_count`=16'hFFFF leaves it at 16'hFFFF.

## Structure
- Package `mult_sched_pkg` holds:
  - `MN1_W`=48, `MN2_W`=16, `RES_W`=32.
  - The state enum `sched_state_t` {IDLE, ISSUE, RESP}.
  - `OVR_CNT_W`=16.
- Sub-module `rr_arbiter` (NREQ param): combinational inputs `req`, `ptr`; outputs one-hot `gnt`, index `gnt_idx`, `any`.
- The existing `mult` is instantiated unchanged inside `mult_sched`, with ports `mn1`, `mn2`, `result`, `ovr`.

## Test plan
- **Single op:** requester 0 presents `mn1`=48'h84FB70D0FE24, `mn2`=16'h35DA with `rsp_ready`=1.
  - Accept is in the first IDLE cycle.
  - `rsp_valid` is high 2 cycles later with `rsp_id`=0.
  - `rsp_result`/`rsp_ovr` equal a standalone `mult` golden instance for the same operands.
- **Sign pair:** requester 1 sends the same `mn1` with `mn2`=16'h35DA, then `mn2`=16'hB5DA.
  - Both responses match golden, and their `rsp_result[31]` values differ.
- **Round-robin:** all 4 requesters are continuously valid, with `ptr`=0 after reset.
  - Response ids are 0,1,2,3,0,…
  - Responses arrive every 3 cycles.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles in RESP.
  - `rsp_*` stay stable, `req_ready`=0, `busy`=1.
  - The response completes one cycle after `rsp_ready`=1.
- **Reset mid-op:** drop `rst_n` during ISSUE.
  - All outputs go to their reset values immediately.
  - No response is emitted.
  - After release, requester 2's pending request is served first if it is the only one valid.
- **Overflow count:** deliver 3 operand pairs that the golden model flags ovr=1 and 2 with ovr=0 → `ovr_count`=3.
  - Force the counter to 16'hFFFF, deliver another ovr → it stays at 16'hFFFF.
